// File: rtl/icache_assoc_if.sv
// Fetch-side request bus plus the AXI4 read channels used for line refill.
// The slave modport is the cache's view; master is the fetch stage / interconnect view.
interface icache_assoc_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int AXI_DATA_W = 64
);
  logic [ADDR_W-1:0]       req_pc;
  logic                    req_rd;
  logic                    inv;
  logic                    req_accept;
  logic [LINE_BYTES*8-1:0] req_data;
  logic                    req_err;
  logic                    busy;

  logic                    axi_arready;
  logic [3:0]              axi_arid;
  logic [ADDR_W-1:0]       axi_araddr;
  logic [7:0]              axi_arlen;
  logic [2:0]              axi_arsize;
  logic [1:0]              axi_arburst;
  logic                    axi_arlock;
  logic [3:0]              axi_arcache;
  logic [2:0]              axi_arprot;
  logic                    axi_arvalid;

  logic [3:0]              axi_rid;
  logic [1:0]              axi_rresp;
  logic                    axi_rvalid;
  logic [AXI_DATA_W-1:0]   axi_rdata;
  logic                    axi_rlast;
  logic                    axi_rready;

  modport slave (
    input  req_pc, req_rd, inv,
    output req_accept, req_data, req_err, busy,
    input  axi_arready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    input  axi_rid, axi_rresp, axi_rvalid, axi_rdata, axi_rlast,
    output axi_rready
  );

  modport master (
    output req_pc, req_rd, inv,
    input  req_accept, req_data, req_err, busy,
    output axi_arready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    output axi_rid, axi_rresp, axi_rvalid, axi_rdata, axi_rlast,
    input  axi_rready
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative (1 or 2 way, 1-bit LRU) instruction cache returning whole lines,
// refilled by a single incrementing AXI4 read burst; supports a per-set invalidate sweep.
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID     = 0
) (
  input  logic           clk,
  input  logic           rst,
  icache_assoc_if.slave  bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LA_W   = ADDR_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / AXI_DATA_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int W1     = (WAYS > 1) ? 1 : 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_R     = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]        state_q;
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [LINE_W-1:0] data_q [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [LA_W-1:0]   line_addr_q;
  logic [CNT_W-1:0]  beat_q;
  logic [IDX_W-1:0]  flush_q;
  logic              err_q, inv_q, hold_q;
  logic [LINE_W-1:0] line_q, line_nxt;

  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic              hit, hit_way, victim;
  logic              flush_go, hit_acc, refill_end, refill_ok;
  logic              unused_ok;

  assign req_tag  = bus.req_pc[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.req_pc[OFF_W +: IDX_W];
  assign fill_tag = line_addr_q[LA_W-1 -: TAG_W];
  assign fill_idx = line_addr_q[IDX_W-1:0];
  assign unused_ok = ^{bus.req_pc[OFF_W-1:0], bus.axi_rid, bus.axi_rlast};

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  always_comb begin
    if (WAYS == 1 || !valid_q[0][fill_idx]) victim = 1'b0;
    else if (!valid_q[W1][fill_idx])         victim = 1'b1;
    else                                     victim = lru_q[fill_idx];
  end

  always_comb begin
    line_nxt = line_q;
    line_nxt[int'(beat_q)*AXI_DATA_W +: AXI_DATA_W] = bus.axi_rdata;
  end

  // A deferred invalidate waits one IDLE cycle after a good refill so the held fetch is served first.
  assign flush_go   = (state_q == S_IDLE) && (bus.inv || inv_q) && !hold_q;
  assign hit_acc    = (state_q == S_IDLE) && bus.req_rd && hit && !flush_go;
  assign refill_end = (state_q == S_R) && bus.axi_rvalid && (beat_q == CNT_W'(BEATS-1));
  assign refill_ok  = refill_end && !err_q && (bus.axi_rresp == 2'b00);

  assign bus.req_accept  = hit_acc || (state_q == S_ERR);
  assign bus.req_err     = (state_q == S_ERR);
  assign bus.req_data    = hit_acc ? data_q[hit_way][req_idx] : '0;
  assign bus.busy        = (state_q != S_IDLE);

  assign bus.axi_arvalid = (state_q == S_AR);
  assign bus.axi_araddr  = {line_addr_q, {OFF_W{1'b0}}};
  assign bus.axi_arlen   = 8'(BEATS - 1);
  assign bus.axi_arsize  = 3'($clog2(AXI_DATA_W/8));
  assign bus.axi_arburst = 2'b01;
  assign bus.axi_arlock  = 1'b0;
  assign bus.axi_arcache = 4'b0011;
  assign bus.axi_arprot  = 3'b100;
  assign bus.axi_arid    = 4'(AXI_ID);
  assign bus.axi_rready  = (state_q == S_R);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      lru_q   <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (flush_go)                            inv_q <= 1'b0;
      else if (bus.inv && state_q != S_FLUSH)  inv_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (flush_go) begin
            state_q <= S_FLUSH;
            flush_q <= '0;
          end else if (bus.req_rd) begin
            if (!hit)             state_q <= S_AR;
            else if (WAYS > 1)    lru_q[req_idx] <= ~hit_way;
          end
        end
        S_AR: begin
          if (bus.axi_arready) begin
            state_q <= S_R;
            beat_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        S_R: begin
          if (bus.axi_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (bus.axi_rresp != 2'b00) err_q <= 1'b1;
            if (refill_end) begin
              if (refill_ok) begin
                valid_q[victim][fill_idx] <= 1'b1;
                if (WAYS > 1) lru_q[fill_idx] <= ~victim;
                hold_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_ERR;
              end
            end
          end
        end
        S_ERR: state_q <= S_IDLE;
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_q] <= 1'b0;
          lru_q[flush_q] <= 1'b0;
          flush_q <= flush_q + 1'b1;
          if (flush_q == IDX_W'(SETS-1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage and the refill line buffer carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req_rd && !hit && !flush_go)
      line_addr_q <= bus.req_pc[ADDR_W-1:OFF_W];
    if (state_q == S_R && bus.axi_rvalid) begin
      line_q <= line_nxt;
      if (refill_ok) begin
        tag_q[victim][fill_idx]  <= fill_tag;
        data_q[victim][fill_idx] <= line_nxt;
      end
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: AXI memory returns word = byte address, fetch results
// are queued as expectations and compared when the cache accepts.
module tb_icache_assoc;
  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 64;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int AXI_DATA_W = 64;

  typedef struct {
    logic [63:0] first;
    logic [63:0] last;
    logic        err;
    int          lat;
    int          ars;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  int          ar_stall = 0;
  int          err_beat = -1;
  int          ar_count = 0;
  int          stab_bad = 0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  logic [2:0]  last_arsize = '0;
  logic [1:0]  last_arburst = '0;

  icache_assoc_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .AXI_DATA_W(AXI_DATA_W)) bus ();

  icache_assoc #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS),
    .AXI_DATA_W(AXI_DATA_W), .AXI_ID(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI memory model: decisions made at negedge for the following rising edge.
  initial begin : axi_mem
    logic        burst;
    logic        stall_seen;
    int          beat;
    logic [31:0] rbase, st_addr;
    logic [7:0]  st_len;
    burst = 1'b0; stall_seen = 1'b0; beat = 0; rbase = '0; st_addr = '0; st_len = '0;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00; bus.axi_rlast = 1'b0; bus.axi_rid = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        burst = 1'b0; beat = 0; stall_seen = 1'b0;
        bus.axi_rvalid = 1'b0; bus.axi_arready = 1'b0;
      end else begin
        if (burst) begin
          bus.axi_rvalid = 1'b1;
          bus.axi_rdata  = 64'(rbase + 32'(beat * 8));
          bus.axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          bus.axi_rlast  = (beat == 7);
          if (bus.axi_rready) begin
            beat++;
            if (beat == 8) burst = 1'b0;
          end
        end else begin
          bus.axi_rvalid = 1'b0;
          bus.axi_rlast  = 1'b0;
        end
        if (bus.axi_arvalid) begin
          if (!stall_seen) begin
            stall_seen = 1'b1; st_addr = bus.axi_araddr; st_len = bus.axi_arlen;
          end else if (bus.axi_araddr !== st_addr || bus.axi_arlen !== st_len) begin
            stab_bad++;
          end
          if (ar_stall > 0) begin
            bus.axi_arready = 1'b0;
            ar_stall--;
          end else begin
            bus.axi_arready = 1'b1;
            stall_seen   = 1'b0;
            ar_count++;
            last_araddr  = bus.axi_araddr;
            last_arlen   = bus.axi_arlen;
            last_arsize  = bus.axi_arsize;
            last_arburst = bus.axi_arburst;
            rbase = bus.axi_araddr;
            burst = 1'b1;
            beat  = 0;
          end
        end else begin
          bus.axi_arready = 1'b0;
        end
      end
    end
  end

  // Present one fetch at negedge (its cycle 0) and check the accept against the queued expectation.
  task automatic fetch(input logic [31:0] pc, input int lat, input logic err,
                       input int ars, input int inv_at);
    exp_t        e;
    int          n, ar0;
    logic [31:0] base;
    string       t;
    t    = $sformatf("pc%0h", pc);
    base = pc & ~32'h3f;
    e.first = err ? 64'd0 : 64'(base);
    e.last  = err ? 64'd0 : 64'(base + 32'h38);
    e.err = err; e.lat = lat; e.ars = ars;
    sb.push_back(e);
    ar0 = ar_count;
    bus.req_pc = pc;
    bus.req_rd = 1'b1;
    n = 0;
    #1;
    while (bus.req_accept !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      bus.inv = (n == inv_at);
      #1;
    end
    bus.inv = 1'b0;
    e = sb.pop_front();
    chk({t, "_accept"}, 64'(bus.req_accept), 64'd1);
    chk({t, "_latency"}, 64'(n), 64'(e.lat));
    chk({t, "_err"}, 64'(bus.req_err), 64'(e.err));
    chk({t, "_data_lo"}, bus.req_data[63:0], e.first);
    chk({t, "_data_hi"}, bus.req_data[511:448], e.last);
    chk({t, "_ar_count"}, 64'(ar_count - ar0), 64'(e.ars));
    @(negedge clk);
    bus.req_rd = 1'b0;
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n, guard;
    n = 0; guard = 0;
    while (bus.busy !== 1'b1 && guard < 3) begin @(negedge clk); guard++; end
    while (bus.busy === 1'b1 && n < 300) begin n++; @(negedge clk); end
    chk(tag, 64'(n), 64'(exp));
  endtask

  initial begin : stim
    bus.req_rd = 1'b0; bus.req_pc = '0; bus.inv = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_accept",  64'(bus.req_accept),  64'd0);
    chk("rst_err",     64'(bus.req_err),     64'd0);
    chk("rst_busy",    64'(bus.busy),        64'd0);
    chk("rst_arvalid", 64'(bus.axi_arvalid), 64'd0);
    chk("rst_rready",  64'(bus.axi_rready),  64'd0);
    chk("rst_data",    64'(|bus.req_data),   64'd0);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h1000, 10, 1'b0, 1, -1);
    chk("ar_addr",  64'(last_araddr),  64'h1000);
    chk("ar_len",   64'(last_arlen),   64'd7);
    chk("ar_size",  64'(last_arsize),  64'd3);
    chk("ar_burst", 64'(last_arburst), 64'd1);
    fetch(32'h1004, 0, 1'b0, 0, -1);
    fetch(32'h1020, 0, 1'b0, 0, -1);

    fetch(32'h0000, 10, 1'b0, 1, -1);
    fetch(32'h1000, 0,  1'b0, 0, -1);
    fetch(32'h0000, 0,  1'b0, 0, -1);
    fetch(32'h2000, 10, 1'b0, 1, -1);
    fetch(32'h0000, 0,  1'b0, 0, -1);
    fetch(32'h1000, 10, 1'b0, 1, -1);

    bus.inv = 1'b1;
    @(negedge clk);
    bus.inv = 1'b0;
    count_busy("flush_idle_busy", 64);
    fetch(32'h1000, 10, 1'b0, 1, -1);

    fetch(32'h3000, 10, 1'b0, 1, 4);
    count_busy("flush_deferred_busy", 64);
    fetch(32'h3000, 10, 1'b0, 1, -1);

    err_beat = 3;
    fetch(32'h4000, 10, 1'b1, 1, -1);
    err_beat = -1;
    fetch(32'h4000, 10, 1'b0, 1, -1);

    bus.req_pc = 32'h5000;
    bus.req_rd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_arvalid", 64'(bus.axi_arvalid), 64'd0);
    chk("midrst_rready",  64'(bus.axi_rready),  64'd0);
    chk("midrst_busy",    64'(bus.busy),        64'd0);
    chk("midrst_accept",  64'(bus.req_accept),  64'd0);
    rst = 1'b1;
    bus.req_rd = 1'b0;
    @(negedge clk);
    ar_stall = 3;
    fetch(32'h5000, 13, 1'b0, 1, -1);
    chk("ar_stall_stable", 64'(stab_bad), 64'd0);
    fetch(32'h5010, 0, 1'b0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with a single AXI4 read master for line refill. It sits between the fetch stage (`req_*`) and the instruction memory interconnect (`axi_*`), and returns one full cache line per accepted request. It generalises the direct-mapped icache with configurable line size, set count, associativity (1 or 2 ways, 1-bit LRU), configurable AXI data width, a sequential invalidate sweep and refill error reporting.

## Interface
- `ADDR_W`, 32: fetch/AXI address width.
- `LINE_BYTES`, 64: line size; power of 2, ≥ `AXI_DATA_W/8`.
- `SETS`, 64: number of sets; power of 2.
- `WAYS`, 2: associativity; legal values 1 and 2.
- `AXI_DATA_W`, 64: R-channel data width; power of 2, 32..512.
- `AXI_ID`, 0: constant ARID value.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_pc` in ADDR_W: fetch address; low log2(LINE_BYTES) bits are ignored.
- `req_rd` in 1: fetch request; the requester holds it and `req_pc` until `req_accept`.
- `inv` in 1: invalidate-all request, sampled as a pulse.
- `req_accept` out 1: the request completes this cycle.
- `req_data` out LINE_BYTES*8: line data, valid while `req_accept`.
- `req_err` out 1: refill error; valid with `req_accept`.
- `busy` out 1: cache is in any state other than IDLE.
- `axi_arready` in 1; `axi_arid` out 4; `axi_araddr` out ADDR_W; `axi_arlen` out 8; `axi_arsize` out 3; `axi_arburst` out 2; `axi_arlock` out 1; `axi_arcache` out 4; `axi_arprot` out 3; `axi_arvalid` out 1.
- `axi_rid` in 4; `axi_rresp` in 2; `axi_rvalid` in 1; `axi_rdata` in AXI_DATA_W; `axi_rlast` in 1; `axi_rready` out 1.

## Operation
- Address split: offset = log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remaining bits. Tag, valid, LRU and data are held in flops.
- States: IDLE, AR, R, ERR, FLUSH.
- IDLE, hit: if `req_rd` and the tag matches a valid way, `req_accept`=1 in the same cycle (combinational) and `req_data` = that way's line. On the accept edge, LRU[set] is set to the other way.
- IDLE, miss: the cache registers the line-aligned address and moves to AR.
- AR: `axi_arvalid`=1 with the following fields held until `axi_arready`:
  - `araddr` = aligned address; `arlen` = BEATS-1, where BEATS = LINE_BYTES*8/AXI_DATA_W.
  - `arsize` = log2(AXI_DATA_W/8); `arburst` = 2'b01; `arlock` = 0; `arcache` = 4'b0011; `arprot` = 3'b100; `arid` = AXI_ID.
- R: `axi_rready`=1.
  - A beat counter places beat k at line bits [k*AXI_DATA_W +: AXI_DATA_W].
  - Any beat with `rresp`≠0 sets a sticky error flag.
  - Completion is on counter = BEATS-1; `rlast` is not used for termination.
- End of refill, no error: the line is written to the victim way, valid is set, LRU is set to the other way, and the state returns to IDLE. The held request then hits.
- End of refill, error: nothing is installed. The state goes to ERR for one cycle, with `req_accept`=1, `req_err`=1 and `req_data`=0, then returns to IDLE.
- Victim selection: way 0 if invalid, else way 1 if invalid, else LRU[set]. With WAYS=1, the victim is always way 0.
- Invalidate: an `inv` pulse is latched.
  - It is acted on in IDLE before any `req_rd` in the same cycle; no accept is given that cycle.
  - During AR/R/ERR it is deferred until return to IDLE.
  - FLUSH clears one set per cycle (valid and LRU) for SETS cycles, then returns to IDLE.
  - An `inv` arriving during FLUSH is absorbed.
- Reset: all valid and LRU bits, the counters and the latched inv are cleared, and the state is IDLE.
  - Outputs after reset: `req_accept`=0, `req_err`=0, `busy`=0, `axi_arvalid`=0, `axi_rready`=0, `req_data`=0.
  - A reset mid-burst abandons the refill; the interconnect is reset together with the cache.

## Timing
- Hit: 0-cycle latency, one accept per cycle for back-to-back hits.
- Miss, with `arready`=1 and `rvalid` continuous (miss detected in cycle 0):
  - `arvalid` is high in cycle 1 and the handshake completes at the end of cycle 1.
  - Beats arrive in cycles 2..BEATS+1.
  - `req_accept` is high in cycle BEATS+2, which is cycle 10 at the defaults.
- An `arready` or `rvalid` stall adds exactly one cycle per stalled cycle.
- `req_accept` is never high outside IDLE or ERR; `busy`=1 in every state except IDLE.

## Test plan
- Cold miss at pc 0x1000, memory word = address, 8 beats -> one AR with araddr 0x1000, arlen 7, arsize 3, arburst 1; `req_accept` in cycle 10; `req_data[63:0]`=0x1000, `[511:448]`=0x1038.
- Repeat at pc 0x1004, then pc 0x1020 -> both accept with 0-cycle latency and no AR issued.
- Same-set sequence 0x0000, 0x1000, 0x0000, 0x2000 (SETS=64, LINE=64) -> 0x2000 evicts 0x1000. A subsequent fetch of 0x0000 hits; 0x1000 misses.
- `inv` pulse while fully populated -> `busy` for 64 cycles. The next fetch of 0x1000 misses; an `inv` during an in-progress refill starts FLUSH only after that refill's accept.
- `rresp`=2'b10 on beat 3 -> ERR cycle with `req_accept`=1, `req_err`=1, `req_data`=0. A refetch of the same pc misses again.
- `rst` low in cycle 5 of a refill -> the next cycle has `arvalid`=0, `rready`=0, `busy`=0. A fetch of the same pc after reset misses. With `arready` held low for 3 cycles, `araddr`/`arlen` stay stable and the accept moves to cycle 13.
